// File: rtl/operand_fwd_ctrl.sv
// operand_fwd_ctrl: tracks EX/MEM producers, registers the four operand-mux selects and stalls decode.
// Define OPERAND_FWD_EN to forward from MEM/WB; without it every RAW hazard stalls until the write-through regfile has the value.

module operand_fwd_ctrl #(
    parameter int RA_W  = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    output logic             id_ready,
    input  logic [RA_W-1:0]  id_src_a0,
    input  logic [RA_W-1:0]  id_src_b0,
    input  logic [RA_W-1:0]  id_src_a1,
    input  logic [RA_W-1:0]  id_src_b1,
    input  logic             id_imm_b0,
    input  logic             id_imm_b1,
    input  logic [RA_W-1:0]  id_dst0,
    input  logic [RA_W-1:0]  id_dst1,
    input  logic             id_wen0,
    input  logic             id_wen1,
    input  logic             id_load0,
    input  logic             id_load1,
    input  logic             flush,
    output logic             ex_valid,
    output logic [1:0]       sel_a0,
    output logic [1:0]       sel_b0,
    output logic [1:0]       sel_a1,
    output logic [1:0]       sel_b1,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        SEL_RF  = 2'b00,
        SEL_MEM = 2'b01,
        SEL_WB  = 2'b10,
        SEL_IMM = 2'b11
    } sel_t;

    logic             r_ex_valid;
    logic [RA_W-1:0]  r_ex_dst0;
    logic [RA_W-1:0]  r_ex_dst1;
    logic             r_ex_wen0;
    logic             r_ex_wen1;
    logic             r_ex_load0;
    logic             r_ex_load1;

    logic             r_mem_valid;
    logic [RA_W-1:0]  r_mem_dst0;
    logic [RA_W-1:0]  r_mem_dst1;
    logic             r_mem_wen0;
    logic             r_mem_wen1;

    sel_t             r_sel [4];
    logic [CNT_W-1:0] r_stall_cnt;

    logic [RA_W-1:0]  w_src [4];
    logic [3:0]       w_use;
    logic [1:0]       w_ex_hit [4];
    logic [1:0]       w_mem_hit [4];
    logic [3:0]       w_ld_use;
`ifndef OPERAND_FWD_EN
    logic [3:0]       w_raw;
`endif
    sel_t             w_sel [4];
    logic             w_hazard;
    logic             w_ready;
    logic             w_accept;

    // Bit 1 = slot-1 producer, bit 0 = slot-0 producer; register 0 never matches.
    function automatic logic [1:0] prod_hit(
        input logic [RA_W-1:0] s,
        input logic            v,
        input logic [RA_W-1:0] d0,
        input logic [RA_W-1:0] d1,
        input logic            e0,
        input logic            e1
    );
        logic [1:0] h;
        h[0] = v && e0 && (d0 == s) && (s != '0);
        h[1] = v && e1 && (d1 == s) && (s != '0);
        return h;
    endfunction

    // Source index order: 0=a0, 1=b0, 2=a1, 3=b1.
    assign w_src[0] = id_src_a0;
    assign w_src[1] = id_src_b0;
    assign w_src[2] = id_src_a1;
    assign w_src[3] = id_src_b1;
    assign w_use    = {~id_imm_b1, 1'b1, ~id_imm_b0, 1'b1};

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            w_ex_hit[i]  = prod_hit(w_src[i], r_ex_valid, r_ex_dst0, r_ex_dst1,
                                    r_ex_wen0, r_ex_wen1);
            w_mem_hit[i] = prod_hit(w_src[i], r_mem_valid, r_mem_dst0, r_mem_dst1,
                                    r_mem_wen0, r_mem_wen1);
            // Slot 1 owns the architectural write, so its load bit decides.
            w_ld_use[i]  = w_use[i] && (w_ex_hit[i][1] ? r_ex_load1
                                                       : (w_ex_hit[i][0] && r_ex_load0));
`ifndef OPERAND_FWD_EN
            w_raw[i]     = w_use[i] && ((|w_ex_hit[i]) || (|w_mem_hit[i]));
`endif
            if (!w_use[i])
                w_sel[i] = SEL_IMM;
`ifdef OPERAND_FWD_EN
            else if (|w_ex_hit[i])
                w_sel[i] = SEL_MEM;
            else if (|w_mem_hit[i])
                w_sel[i] = SEL_WB;
`endif
            else
                w_sel[i] = SEL_RF;
        end
    end

`ifdef OPERAND_FWD_EN
    assign w_hazard = id_valid && (|w_ld_use);
`else
    assign w_hazard = id_valid && ((|w_raw) || (|w_ld_use));
`endif

    assign w_ready  = !flush && !w_hazard;
    assign w_accept = id_valid && w_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ex_valid  <= 1'b0;
            r_ex_dst0   <= '0;
            r_ex_dst1   <= '0;
            r_ex_wen0   <= 1'b0;
            r_ex_wen1   <= 1'b0;
            r_ex_load0  <= 1'b0;
            r_ex_load1  <= 1'b0;
            r_mem_valid <= 1'b0;
            r_mem_dst0  <= '0;
            r_mem_dst1  <= '0;
            r_mem_wen0  <= 1'b0;
            r_mem_wen1  <= 1'b0;
            for (int unsigned i = 0; i < 4; i++)
                r_sel[i] <= SEL_RF;
            r_stall_cnt <= '0;
        end else begin
            // A flushed EX bundle must not resurface as a MEM producer.
            r_mem_valid <= r_ex_valid && !flush;
            r_mem_dst0  <= r_ex_dst0;
            r_mem_dst1  <= r_ex_dst1;
            r_mem_wen0  <= r_ex_wen0;
            r_mem_wen1  <= r_ex_wen1;
            r_ex_valid  <= w_accept;
            r_ex_dst0   <= id_dst0;
            r_ex_dst1   <= id_dst1;
            r_ex_wen0   <= id_wen0;
            r_ex_wen1   <= id_wen1;
            r_ex_load0  <= id_load0;
            r_ex_load1  <= id_load1;
            for (int unsigned i = 0; i < 4; i++)
                r_sel[i] <= w_accept ? w_sel[i] : SEL_RF;
            if (id_valid && !w_ready && !flush && !(&r_stall_cnt))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign id_ready  = w_ready;
    assign ex_valid  = r_ex_valid;
    assign sel_a0    = r_sel[0];
    assign sel_b0    = r_sel[1];
    assign sel_a1    = r_sel[2];
    assign sel_b1    = r_sel[3];
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_operand_fwd_ctrl.sv
// Scoreboard bench for operand_fwd_ctrl: age-based producer model, random plus directed stimulus.
// Honours OPERAND_FWD_EN the same way the design does.

module tb_operand_fwd_ctrl;

    localparam int RA_W  = 5;
    localparam int CNT_W = 16;
`ifdef OPERAND_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             id_valid;
    logic             id_ready;
    logic [RA_W-1:0]  id_src_a0, id_src_b0, id_src_a1, id_src_b1;
    logic             id_imm_b0, id_imm_b1;
    logic [RA_W-1:0]  id_dst0, id_dst1;
    logic             id_wen0, id_wen1, id_load0, id_load1;
    logic             flush;
    logic             ex_valid;
    logic [1:0]       sel_a0, sel_b0, sel_a1, sel_b1;
    logic [CNT_W-1:0] stall_cnt;

    operand_fwd_ctrl #(.RA_W(RA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_ready(id_ready),
        .id_src_a0(id_src_a0), .id_src_b0(id_src_b0), .id_src_a1(id_src_a1), .id_src_b1(id_src_b1),
        .id_imm_b0(id_imm_b0), .id_imm_b1(id_imm_b1), .id_dst0(id_dst0), .id_dst1(id_dst1),
        .id_wen0(id_wen0), .id_wen1(id_wen1), .id_load0(id_load0), .id_load1(id_load1),
        .flush(flush), .ex_valid(ex_valid), .sel_a0(sel_a0), .sel_b0(sel_b0),
        .sel_a1(sel_a1), .sel_b1(sel_b1), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Every accepted bundle, tagged with the edge on which it entered EX.
    typedef struct {
        int         e_a;
        bit         killed;
        logic [4:0] d0, d1;
        bit         w0, w1, l0, l1;
    } prod_t;
    typedef struct {
        logic [1:0] a0, b0, a1, b1;
    } exp_t;

    prod_t hist[$];
    exp_t  sbq[$];
    int    checks = 0;
    int    errors = 0;
    int    cur_edge = 0;
    int    exp_stall = 0;
    int    n_acc = 0;
    int    n_seen = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Youngest live producer of s that is 0 (EX) or 1 (MEM) edges old; slot 1 preferred.
    function automatic void lookup(input logic [4:0] s, output int age, output bit ld);
        age = -1;
        ld  = 1'b0;
        if (s == 5'd0) return;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            int a;
            a = cur_edge - hist[i].e_a;
            if (!hist[i].killed && a >= 0 && a <= 1) begin
                if (hist[i].w1 && hist[i].d1 == s) begin
                    age = a; ld = hist[i].l1; return;
                end
                if (hist[i].w0 && hist[i].d0 == s) begin
                    age = a; ld = hist[i].l0; return;
                end
            end
        end
    endfunction

    task automatic cycle(input bit v, input logic [4:0] a0, b0, a1, b1, input bit ib0, ib1,
                         input logic [4:0] d0, d1, input bit w0, w1, l0, l1, input bit fl,
                         output bit acc);
        logic [4:0] s [4];
        bit         use_ [4];
        logic [1:0] e [4];
        bit         hz;
        bit         rdy;
        int         age;
        bit         ld;
        id_valid = v; id_src_a0 = a0; id_src_b0 = b0; id_src_a1 = a1; id_src_b1 = b1;
        id_imm_b0 = ib0; id_imm_b1 = ib1; id_dst0 = d0; id_dst1 = d1;
        id_wen0 = w0; id_wen1 = w1; id_load0 = l0; id_load1 = l1; flush = fl;
        #1;
        s[0] = a0; s[1] = b0; s[2] = a1; s[3] = b1;
        use_ = '{1'b1, !ib0, 1'b1, !ib1};
        hz = 1'b0;
        for (int i = 0; i < 4; i++) begin
            lookup(s[i], age, ld);
            if (!use_[i])                e[i] = 2'b11;
            else if (!FWD || age < 0)    e[i] = 2'b00;
            else if (age == 0)           e[i] = 2'b01;
            else                         e[i] = 2'b10;
            if (use_[i] && age >= 0 && (!FWD || (age == 0 && ld))) hz = 1'b1;
        end
        rdy = !fl && !(v && hz);
        chk("id_ready", {31'd0, id_ready}, {31'd0, rdy});
        chk("stall_cnt", {16'd0, stall_cnt}, exp_stall);
        if (v && !rdy && !fl && exp_stall < 65535) exp_stall++;
        if (fl)
            foreach (hist[i]) if (hist[i].e_a == cur_edge) hist[i].killed = 1'b1;
        acc = v && rdy;
        if (acc) begin
            sbq.push_back('{e[0], e[1], e[2], e[3]});
            hist.push_back('{cur_edge + 1, 1'b0, d0, d1, w0, w1, l0, l1});
            n_acc++;
        end
        cur_edge++;
        while (hist.size() > 0 && cur_edge - hist[0].e_a > 1) void'(hist.pop_front());
        @(negedge clk);
    endtask

    task automatic issue(input logic [4:0] a0, b0, a1, b1, input bit ib0, ib1,
                         input logic [4:0] d0, d1, input bit w0, w1, l0, l1);
        bit acc;
        int tries;
        acc = 1'b0;
        tries = 0;
        while (!acc && tries < 8) begin
            cycle(1'b1, a0, b0, a1, b1, ib0, ib1, d0, d1, w0, w1, l0, l1, 1'b0, acc);
            tries++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: not accepted after %0d cycles", tries);
        end
    endtask

    task automatic idle(input bit fl);
        bit acc;
        cycle(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, fl, acc);
    endtask

    // Called at a falling edge; asserts reset asynchronously mid-cycle.
    task automatic do_reset();
        id_valid = 1'b0;
        flush = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("rst_ex_valid", {31'd0, ex_valid}, 0);
        chk("rst_sel_a0", {30'd0, sel_a0}, 0);
        chk("rst_sel_b0", {30'd0, sel_b0}, 0);
        chk("rst_sel_a1", {30'd0, sel_a1}, 0);
        chk("rst_sel_b1", {30'd0, sel_b1}, 0);
        chk("rst_stall_cnt", {16'd0, stall_cnt}, 0);
        chk("rst_id_ready", {31'd0, id_ready}, 1);
        hist.delete();
        sbq.delete();
        exp_stall = 0;
        @(negedge clk);
        reset = 1'b0;
        cur_edge++;
    endtask

    // Monitor: each live EX bundle is matched against the oldest expected entry.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!reset && ex_valid === 1'b1) begin
                n_seen++;
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ex_valid_unexpected: got 1 expected 0 (t=%0t)", $time);
                end else begin
                    e = sbq.pop_front();
                    chk("sel_a0", {30'd0, sel_a0}, {30'd0, e.a0});
                    chk("sel_b0", {30'd0, sel_b0}, {30'd0, e.b0});
                    chk("sel_a1", {30'd0, sel_a1}, {30'd0, e.a1});
                    chk("sel_b1", {30'd0, sel_b1}, {30'd0, e.b1});
                end
            end
        end
    end

    initial begin
        bit acc;
        reset = 1'b1;
        id_valid = 1'b0; flush = 1'b0;
        id_src_a0 = '0; id_src_b0 = '0; id_src_a1 = '0; id_src_b1 = '0;
        id_imm_b0 = 1'b0; id_imm_b1 = 1'b0; id_dst0 = '0; id_dst1 = '0;
        id_wen0 = 1'b0; id_wen1 = 1'b0; id_load0 = 1'b0; id_load1 = 1'b0;
        @(negedge clk);
        do_reset();

        // ALU chain on r3: selects 01, 10, 00 with forwarding
        issue(5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 5'd3, 5'd0, 1, 0, 0, 0);
        issue(5'd3, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0, 5'd0, 0, 0, 0, 0);
        issue(5'd3, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0, 5'd0, 0, 0, 0, 0);
        issue(5'd3, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0, 5'd0, 0, 0, 0, 0);
        // Same-stage double write of r7, register then immediate on b1
        issue(5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 5'd7, 5'd7, 1, 1, 1, 0);
        issue(5'd0, 5'd0, 5'd0, 5'd7, 0, 0, 5'd0, 5'd0, 0, 0, 0, 0);
        issue(5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 5'd7, 5'd7, 1, 1, 0, 0);
        issue(5'd0, 5'd0, 5'd0, 5'd7, 0, 1, 5'd0, 5'd0, 0, 0, 0, 0);
        // Load-use through slot 1, then r0 never matches
        issue(5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0, 5'd9, 0, 1, 0, 1);
        issue(5'd9, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0, 5'd0, 0, 0, 0, 0);
        issue(5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0, 5'd0, 1, 0, 1, 0);
        issue(5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0, 5'd0, 0, 0, 0, 0);
        // Flushed producer of r4 is never forwarded
        issue(5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 5'd4, 5'd0, 1, 0, 0, 0);
        idle(1'b1);
        issue(5'd4, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0, 5'd0, 0, 0, 0, 0);
        // ALU producer r5 then consumer
        issue(5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 5'd5, 5'd0, 1, 0, 0, 0);
        issue(5'd0, 5'd5, 5'd0, 5'd0, 0, 0, 5'd0, 5'd0, 0, 0, 0, 0);
        // Reset with EX and MEM live
        issue(5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 5'd3, 5'd0, 1, 0, 0, 0);
        issue(5'd3, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0, 5'd0, 0, 0, 0, 0);
        do_reset();
        // Reset in the middle of a load-use stall
        issue(5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0, 5'd9, 0, 1, 0, 1);
        cycle(1'b1, 5'd9, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0, 5'd0, 0, 0, 0, 0, 1'b0, acc);
        do_reset();
        cycle(1'b1, 5'd9, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0, 5'd0, 0, 0, 0, 0, 1'b0, acc);

        for (int n = 0; n < 3000; n++) begin
            if (n % 1000 == 999) do_reset();
            cycle(($urandom % 4) != 0,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  ($urandom % 4) == 0, ($urandom % 4) == 0,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  ($urandom % 4) != 0, ($urandom % 4) != 0,
                  ($urandom % 3) == 0, ($urandom % 3) == 0,
                  ($urandom % 12) == 0, acc);
        end

        idle(1'b0);
        idle(1'b0);
        chk("scoreboard_drained", sbq.size(), 0);
        chk("bundles_seen", n_seen, n_acc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
